// File: rtl/ro_meas_pkg.sv
// ---------------------------------------------------------------------------
// ro_meas_pkg
// Shared definitions for the ring-oscillator frequency counter.
//   state_e        : measurement FSM states (IDLE, SETTLE, MEASURE, HOLD)
//   SETTLE_CYCLES  : cycles spent with the ring enabled before counting, so
//                    the ring can start and the synchronizer can flush.
// ---------------------------------------------------------------------------
package ro_meas_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    localparam int SETTLE_CYCLES = 4;

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous level into the clk domain through a SYNC_STAGES
// flop chain and emits a one-clk pulse for every rising edge seen at the
// end of the chain.
//
// Parameters:
//   SYNC_STAGES : synchronizer depth, legal range 2..3
// Ports:
//   clk   in   sampling clock
//   rn    in   asynchronous active-low reset; clears the whole chain
//   din   in   asynchronous level to be sampled
//   rise  out  one-cycle pulse per synchronized rising edge
// ---------------------------------------------------------------------------
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rn,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Pulse is decoded from two registered values, so it is glitch-free and
    // lasts exactly one cycle per low-to-high transition.
    assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/ro_freq_counter.sv
// ---------------------------------------------------------------------------
// ro_freq_counter
// Ring-oscillator frequency counter. Enables a gated ring, lets it settle,
// counts synchronized rising edges of the ring output over a programmable
// window of CLK cycles and presents the result on a valid/ready handshake.
//
// Handshake: VALID is high in HOLD only; COUNT and OVF are frozen while
// VALID is high. A transfer happens on a rising CLK edge where VALID and
// READY are both high; VALID drops in the following cycle. START is only
// honoured in IDLE, so a START coinciding with the transfer is ignored.
//
// Configuration macro: RO_PRESCALE_EN
//   defined   : RO_IN is divided by 2 by a toggle flop clocked by RO_IN
//               before the synchronizer; COUNT reports ring periods / 2.
//   undefined : RO_IN feeds the synchronizer directly.
//
// Parameters:
//   CNT_W        edge count width
//   WIN_W        window length width (must be >= 2)
//   SYNC_STAGES  synchronizer depth, 2..3
// Ports:
//   CLK     in   system clock
//   RN      in   asynchronous active-low reset
//   START   in   one-cycle measurement request (IDLE only)
//   WINDOW  in   window length in CLK cycles, sampled with START
//   RO_IN   in   asynchronous ring output
//   RO_EN   out  ring enable (SETTLE and MEASURE)
//   BUSY    out  high whenever not IDLE
//   COUNT   out  edge count result
//   OVF     out  count saturated, qualified by VALID
//   VALID   out  result available
//   READY   in   consumer accepts result
//   STATE   out  current FSM state, for observation
// ---------------------------------------------------------------------------
module ro_freq_counter
    import ro_meas_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic             RO_IN,
    output logic             RO_EN,
    output logic             BUSY,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF,
    output logic             VALID,
    input  logic             READY,
    output logic [1:0]       STATE
);

    localparam logic [WIN_W-1:0] WIN_ONE     = WIN_W'(1);
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e           state_q;
    state_e           state_d;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] tmr_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             ro_src;
    logic             rise;

    // -----------------------------------------------------------------------
    // Optional divide-by-2 prescaler in the ring clock domain
    // -----------------------------------------------------------------------
`ifdef RO_PRESCALE_EN
    logic ro_div_q;

    always_ff @(posedge RO_IN or negedge RN) begin
        if (!RN) begin
            ro_div_q <= 1'b0;
        end else begin
            ro_div_q <= ~ro_div_q;
        end
    end

    assign ro_src = ro_div_q;
`else
    assign ro_src = RO_IN;
`endif

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (CLK),
        .rn  (RN),
        .din (ro_src),
        .rise(rise)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state. tmr_q counts down the remaining cycles of the
    // current timed state and reaches zero in its last cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (START) state_d = SETTLE;
            end
            SETTLE: begin
                if (tmr_q == '0) state_d = (win_q != '0) ? MEASURE : HOLD;
            end
            MEASURE: begin
                if (tmr_q == '0) state_d = HOLD;
            end
            HOLD: begin
                if (READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (pure decode of the registered state)
    // -----------------------------------------------------------------------
    always_comb begin
        RO_EN = (state_q == SETTLE) || (state_q == MEASURE);
        BUSY  = (state_q != IDLE);
        VALID = (state_q == HOLD);
    end

    // -----------------------------------------------------------------------
    // Datapath: window latch, shared cycle timer, saturating edge count
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            win_q   <= '0;
            tmr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        win_q   <= WINDOW;
                        tmr_q   <= SETTLE_LAST;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                SETTLE: begin
                    // Preload for MEASURE; the value is unused if win_q is 0.
                    if (tmr_q == '0) begin
                        tmr_q <= win_q - WIN_ONE;
                    end else begin
                        tmr_q <= tmr_q - WIN_ONE;
                    end
                end
                MEASURE: begin
                    if (tmr_q != '0) begin
                        tmr_q <= tmr_q - WIN_ONE;
                    end
                    // Only pulses arriving inside the window are counted;
                    // anything still in the synchronizer at the end is lost.
                    if (rise) begin
                        if (&count_q) begin
                            ovf_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign COUNT = count_q;
    assign OVF   = ovf_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// ---------------------------------------------------------------------------
// tb_ro_freq_counter
// Self-checking bench for ro_freq_counter. Two instances share all inputs:
// a 16-bit counter and a 4-bit counter that saturates quickly. The ring
// output is generated synchronously with a programmable period/high time;
// every rising edge is logged and the expected count is derived from the
// logged edge times and the documented start-to-window and edge-to-count
// latencies.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ro_freq_counter;
    import ro_meas_pkg::*;

    localparam int CNT_W = 16;
    localparam int WIN_W = 16;
    localparam int SYNC  = 2;
    localparam int SAT_W = 4;
    localparam longint MAX_MAIN = (1 << CNT_W) - 1;
    localparam longint MAX_SAT  = (1 << SAT_W) - 1;
`ifdef RO_PRESCALE_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    typedef struct {
        int win;
        int period;
        int high;
        int lat;
        int cnt_lo;
        int cnt_hi;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rn = 1'b0;
    logic start = 1'b0;
    logic ro_in = 1'b0;
    logic ready = 1'b0;
    logic [WIN_W-1:0] window = '0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic             ro_en, busy, ovf, valid;
    logic [CNT_W-1:0] count;
    logic [1:0]       state;
    logic             s_ro_en, s_busy, s_ovf, s_valid;
    logic [SAT_W-1:0] s_count;
    logic [1:0]       s_state;

    ro_freq_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(SYNC)) dut (
        .CLK(clk), .RN(rn), .START(start), .WINDOW(window), .RO_IN(ro_in),
        .RO_EN(ro_en), .BUSY(busy), .COUNT(count), .OVF(ovf), .VALID(valid),
        .READY(ready), .STATE(state)
    );

    ro_freq_counter #(.CNT_W(SAT_W), .WIN_W(WIN_W), .SYNC_STAGES(SYNC)) dut_sat (
        .CLK(clk), .RN(rn), .START(start), .WINDOW(window), .RO_IN(ro_in),
        .RO_EN(s_ro_en), .BUSY(s_busy), .COUNT(s_count), .OVF(s_ovf), .VALID(s_valid),
        .READY(ready), .STATE(s_state)
    );

    // ---------------- ring output generator ----------------
    int   ro_period = 4;
    int   ro_high   = 2;
    int   ro_phase  = 0;
    logic ro_nxt;
    int   rise_q[$];

    always @(posedge clk) begin
        #1;
        if (ro_phase + 1 >= ro_period) ro_phase = 0;
        else ro_phase = ro_phase + 1;
        ro_nxt = (ro_phase < ro_high);
        if (ro_nxt && !ro_in) rise_q.push_back(cyc);
        ro_in = ro_nxt;
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint lo, input longint hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    function automatic longint min_l(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    // Edges driven in the cycle after bench cycle d are captured at edge
    // d+1 and counted SYNC edges later; START driven after bench cycle s
    // is captured at edge s+1 and counting edges are s+6 .. s+5+w.
    function automatic int model_edges(input int s, input int w);
        int n;
        n = 0;
        foreach (rise_q[i]) begin
            if (rise_q[i] - s >= 5 - SYNC && rise_q[i] - s <= 4 + w - SYNC) n++;
        end
        return n;
    endfunction

    task automatic check_model(input string tag, input int s, input int w);
        int n;
        longint lo, hi;
        n  = model_edges(s, w);
        lo = n / DIV;
        hi = (n + DIV - 1) / DIV;
        chk({tag, "_valid"}, valid & s_valid, 1, 1);
        chk({tag, "_state_hold"}, state, longint'(HOLD), longint'(HOLD));
        chk({tag, "_count"}, count, min_l(lo, MAX_MAIN), min_l(hi, MAX_MAIN));
        chk({tag, "_ovf"}, ovf, longint'(lo > MAX_MAIN), longint'(hi > MAX_MAIN));
        chk({tag, "_sat_count"}, s_count, min_l(lo, MAX_SAT), min_l(hi, MAX_SAT));
        chk({tag, "_sat_ovf"}, s_ovf, longint'(lo > MAX_SAT), longint'(hi > MAX_SAT));
    endtask

    // ---------------- driver tasks (entered/left at +1 after an edge) ----
    task automatic run_meas(input int w, input int poke, output int lat, output int s,
                            output int bad);
        window = WIN_W'(w);
        start  = 1'b1;
        s      = cyc;
        rise_q.delete();
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        bad   = 0;
        while (!valid && lat < w + 50) begin
            if (!ro_en || !busy) bad++;
            if (lat == poke) begin
                start  = 1'b1;
                window = WIN_W'(5);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        if (ro_en) bad++;
    endtask

    task automatic ack_with_start();
        ready  = 1'b1;
        start  = 1'b1;
        window = WIN_W'(7);
        @(posedge clk); #1;
        ready = 1'b0;
        start = 1'b0;
        chk("ack_valid_drop", valid | s_valid, 0, 0);
        chk("ack_start_ignored", busy | s_busy, 0, 0);
        @(posedge clk); #1;
        chk("ack_stay_idle", busy | ro_en, 0, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t tbl[6];
        int   lat, s, bad, seen, w, poke;

        tbl[0] = '{100, 4, 2, 105, 24, 26};
        tbl[1] = '{  0, 4, 2,   5,  0,  0};
        tbl[2] = '{ 60, 3, 1,  65, 19, 21};
        tbl[3] = '{  8, 8, 4,  13,  0,  2};
        tbl[4] = '{  1, 2, 1,   6,  0,  1};
        tbl[5] = '{ 33, 5, 3,  38,  5,  8};

        // Reset held with the ring toggling: everything stays at zero.
        rn = 1'b0;
        ro_period = 2;
        ro_high   = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("reset_flags", {ro_en, busy, valid, ovf}, 0, 0);
            chk("reset_count", count, 0, 0);
            chk("reset_sat", {s_ro_en, s_busy, s_valid, s_ovf, s_count}, 0, 0);
        end
        chk("reset_state", state, longint'(IDLE), longint'(IDLE));
        #1 rn = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid || busy || ro_en) seen++;
            @(posedge clk); #1;
        end
        chk("idle_without_start", seen, 0, 0);

        // Table-driven directed measurements.
        for (int i = 0; i < 6; i++) begin
            ro_period = tbl[i].period;
            ro_high   = tbl[i].high;
            repeat (3) @(posedge clk);
            #1;
            run_meas(tbl[i].win, -1, lat, s, bad);
            chk("tbl_latency", lat, tbl[i].lat, tbl[i].lat);
            chk("tbl_ro_en", bad, 0, 0);
            chk("tbl_count_range", count, tbl[i].cnt_lo / DIV, (tbl[i].cnt_hi + DIV - 1) / DIV);
            check_model("tbl", s, tbl[i].win);
            ack_with_start();
        end

        // Hold the result with READY low: VALID/COUNT stay put for 10 cycles.
        ro_period = 4;
        ro_high   = 2;
        run_meas(20, -1, lat, s, bad);
        chk("hold_latency", lat, 25, 25);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_model("hold", s, 20);
        end
        ack_with_start();

        // START while busy is ignored; the original window stands.
        run_meas(40, 20, lat, s, bad);
        chk("busy_start_latency", lat, 45, 45);
        chk("busy_start_ro_en", bad, 0, 0);
        check_model("busy_start", s, 40);
        ack_with_start();

        // Reset in the middle of MEASURE, then a clean measurement.
        window = WIN_W'(100);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rn = 1'b0;
        #1;
        chk("midreset_flags", {ro_en, busy, valid, ovf}, 0, 0);
        chk("midreset_count", count, 0, 0);
        chk("midreset_state", state, longint'(IDLE), longint'(IDLE));
        @(posedge clk);
        #2 rn = 1'b1;
        @(posedge clk); #1;
        chk("after_reset_idle", busy, 0, 0);
        run_meas(100, -1, lat, s, bad);
        chk("after_reset_latency", lat, 105, 105);
        chk("after_reset_count_range", count, 24 / DIV, (26 + DIV - 1) / DIV);
        check_model("after_reset", s, 100);
        ack_with_start();

        // Randomized measurements against the edge-log model.
        for (int i = 0; i < 12; i++) begin
            w         = $urandom_range(0, 80);
            ro_period = $urandom_range(2, 9);
            ro_high   = $urandom_range(1, ro_period - 1);
            poke      = ($urandom_range(0, 1) == 1) ? $urandom_range(1, w + 4) : -1;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            run_meas(w, poke, lat, s, bad);
            chk("rnd_latency", lat, w + 5, w + 5);
            chk("rnd_ro_en", bad, 0, 0);
            check_model("rnd", s, w);
            ack_with_start();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
